// File: rtl/bp_mmu_ptw.sv
// bp_mmu_ptw: hardware page-table walker.
//
// Takes one TLB-miss walk at a time, reads one PTE per level starting from
// the root PPN, and returns the leaf translation (PPN, superpage level, PTE
// flags) or a page fault. Depth and widths are parameters, so SV39 and SV48
// use the same block.
//
// Ports
//   clk_i, reset_n_i       clock, synchronous active-low reset
//   satp_ppn_i             root page-table PPN, sampled when a walk is accepted
//   walk_v_i/walk_vpn_i    walk request, accepted when walk_ready_o is high
//   walk_ready_o           idle and out of reset
//   mem_req_*              PTE read request (valid/ready, byte address)
//   mem_resp_v_i/data_i    PTE read data; always sunk while waiting
//   fill_*                 walk result (valid/ready, vpn, ppn, level, flags, fault)
module bp_mmu_ptw #(
  parameter int vaddr_width_p       = 39,
  parameter int paddr_width_p       = 56,
  parameter int page_table_depth_p  = 3,
  parameter int pte_width_p         = 64,
  parameter int page_offset_width_p = 12,
  localparam int vpn_w  = vaddr_width_p - page_offset_width_p,
  localparam int ppn_w  = paddr_width_p - page_offset_width_p,
  localparam int idx_w  = vpn_w / page_table_depth_p,
  localparam int lvl_w  = (page_table_depth_p > 1) ? $clog2(page_table_depth_p) : 1,
  localparam int pte_sh = page_offset_width_p - idx_w
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [ppn_w-1:0]         satp_ppn_i,
  input  logic                     walk_v_i,
  input  logic [vpn_w-1:0]         walk_vpn_i,
  output logic                     walk_ready_o,
  output logic                     mem_req_v_o,
  output logic [paddr_width_p-1:0] mem_req_addr_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_v_i,
  input  logic [pte_width_p-1:0]   mem_resp_data_i,
  output logic                     fill_v_o,
  input  logic                     fill_ready_i,
  output logic [vpn_w-1:0]         fill_vpn_o,
  output logic [ppn_w-1:0]         fill_ppn_o,
  output logic [lvl_w-1:0]         fill_level_o,
  output logic [7:0]               fill_flags_o,
  output logic                     fill_fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               live_q;
  logic [vpn_w-1:0]   vpn_q, vpn_d;
  logic [ppn_w-1:0]   base_q, base_d;
  logic [lvl_w-1:0]   level_q, level_d;
  logic [ppn_w-1:0]   fill_ppn_q, fill_ppn_d;
  logic [lvl_w-1:0]   fill_level_q, fill_level_d;
  logic [7:0]         fill_flags_q, fill_flags_d;
  logic               fill_fault_q, fill_fault_d;

  // PTE decode
  logic               pte_v, pte_r, pte_w, pte_x;
  logic [ppn_w-1:0]   pte_ppn;
  logic [ppn_w-1:0]   lo_mask;
  logic [ppn_w-1:0]   vpn_ext;
  logic [idx_w-1:0]   cur_idx;
  logic               pte_unused;

  assign pte_v   = mem_resp_data_i[0];
  assign pte_r   = mem_resp_data_i[1];
  assign pte_w   = mem_resp_data_i[2];
  assign pte_x   = mem_resp_data_i[3];
  assign pte_ppn = mem_resp_data_i[10 +: ppn_w];
  // Only the flag and PPN fields matter; the rest of the PTE is dropped.
  assign pte_unused = ^mem_resp_data_i;

  // PPN bits below the current level: must be zero for an aligned superpage,
  // and are taken from the VPN in the result. All-zero at level 0.
  assign lo_mask = ~({ppn_w{1'b1}} << (int'(level_q) * idx_w));
  assign vpn_ext = ppn_w'(vpn_q);
  assign cur_idx = idx_w'(vpn_q >> (int'(level_q) * idx_w));

  // Gating with live_q keeps ready low while reset is held, without a
  // combinational path from reset_n_i.
  assign walk_ready_o   = (state_q == S_IDLE) && live_q;
  assign mem_req_v_o    = (state_q == S_SEND);
  assign mem_req_addr_o = {base_q, cur_idx, {pte_sh{1'b0}}};
  assign fill_v_o       = (state_q == S_DONE);
  assign fill_vpn_o     = vpn_q;
  assign fill_ppn_o     = fill_ppn_q;
  assign fill_level_o   = fill_level_q;
  assign fill_flags_o   = fill_flags_q;
  assign fill_fault_o   = fill_fault_q;

  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    base_d       = base_q;
    level_d      = level_q;
    fill_ppn_d   = fill_ppn_q;
    fill_level_d = fill_level_q;
    fill_flags_d = fill_flags_q;
    fill_fault_d = fill_fault_q;
    case (state_q)
      S_IDLE: if (walk_v_i && walk_ready_o) begin
        vpn_d   = walk_vpn_i;
        base_d  = satp_ppn_i;
        level_d = lvl_w'(page_table_depth_p - 1);
        state_d = S_SEND;
      end
      S_SEND: if (mem_req_ready_i) state_d = S_WAIT;
      S_WAIT: if (mem_resp_v_i) begin
        if (!pte_v || (!pte_r && pte_w) || (pte_r || pte_x) || (level_q == '0)) begin
          // Walk terminates here: leaf, invalid PTE, or pointer at level 0.
          state_d      = S_DONE;
          fill_level_d = level_q;
          fill_flags_d = mem_resp_data_i[7:0];
          fill_ppn_d   = '0;
          fill_fault_d = 1'b1;
          if (pte_v && !(!pte_r && pte_w) && (pte_r || pte_x) &&
              ((pte_ppn & lo_mask) == '0)) begin
            fill_fault_d = 1'b0;
            fill_ppn_d   = (pte_ppn & ~lo_mask) | (vpn_ext & lo_mask);
          end
        end else begin
          // Pointer to the next-level table; level > 0 here, so no wrap.
          base_d  = pte_ppn;
          level_d = level_q - 1'b1;
          state_d = S_SEND;
        end
      end
      S_DONE: if (fill_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      live_q       <= 1'b0;
      vpn_q        <= '0;
      base_q       <= '0;
      level_q      <= '0;
      fill_ppn_q   <= '0;
      fill_level_q <= '0;
      fill_flags_q <= '0;
      fill_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      live_q       <= 1'b1;
      vpn_q        <= vpn_d;
      base_q       <= base_d;
      level_q      <= level_d;
      fill_ppn_q   <= fill_ppn_d;
      fill_level_q <= fill_level_d;
      fill_flags_q <= fill_flags_d;
      fill_fault_q <= fill_fault_d;
    end
  end

endmodule

// File: tb/tb_bp_mmu_ptw.sv
// Bench for bp_mmu_ptw: an SV39 instance and an SV48-style 4-level instance
// share one stimulus path, selected by sel. Expected request addresses, PTE
// responses and fills are queued up front and consumed as the walk runs.
module tb_bp_mmu_ptw;

  logic        gclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic [43:0] satp = '0;
  logic        walk_v = 1'b0;
  logic [35:0] walk_vpn = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_v = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        fill_ready = 1'b0;

  logic        r3_walk_ready, r3_req_v, r3_fill_v, r3_fill_fault;
  logic [55:0] r3_req_addr;
  logic [26:0] r3_fill_vpn;
  logic [43:0] r3_fill_ppn;
  logic [1:0]  r3_fill_level;
  logic [7:0]  r3_fill_flags;

  logic        r4_walk_ready, r4_req_v, r4_fill_v, r4_fill_fault;
  logic [55:0] r4_req_addr;
  logic [35:0] r4_fill_vpn;
  logic [43:0] r4_fill_ppn;
  logic [1:0]  r4_fill_level;
  logic [7:0]  r4_fill_flags;

  always #5 gclk = ~gclk;

  bp_mmu_ptw dut (
    .clk_i(gclk), .reset_n_i(reset_n), .satp_ppn_i(satp),
    .walk_v_i(walk_v & ~sel), .walk_vpn_i(walk_vpn[26:0]), .walk_ready_o(r3_walk_ready),
    .mem_req_v_o(r3_req_v), .mem_req_addr_o(r3_req_addr), .mem_req_ready_i(mem_req_ready),
    .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data),
    .fill_v_o(r3_fill_v), .fill_ready_i(fill_ready), .fill_vpn_o(r3_fill_vpn),
    .fill_ppn_o(r3_fill_ppn), .fill_level_o(r3_fill_level), .fill_flags_o(r3_fill_flags),
    .fill_fault_o(r3_fill_fault)
  );

  bp_mmu_ptw #(.vaddr_width_p(48), .page_table_depth_p(4)) dut4 (
    .clk_i(gclk), .reset_n_i(reset_n), .satp_ppn_i(satp),
    .walk_v_i(walk_v & sel), .walk_vpn_i(walk_vpn), .walk_ready_o(r4_walk_ready),
    .mem_req_v_o(r4_req_v), .mem_req_addr_o(r4_req_addr), .mem_req_ready_i(mem_req_ready),
    .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data),
    .fill_v_o(r4_fill_v), .fill_ready_i(fill_ready), .fill_vpn_o(r4_fill_vpn),
    .fill_ppn_o(r4_fill_ppn), .fill_level_o(r4_fill_level), .fill_flags_o(r4_fill_flags),
    .fill_fault_o(r4_fill_fault)
  );

  logic        walk_ready, req_v, fill_v, fill_fault;
  logic [55:0] req_addr;
  logic [35:0] fill_vpn;
  logic [43:0] fill_ppn;
  logic [1:0]  fill_level;
  logic [7:0]  fill_flags;

  assign walk_ready = sel ? r4_walk_ready : r3_walk_ready;
  assign req_v      = sel ? r4_req_v      : r3_req_v;
  assign req_addr   = sel ? r4_req_addr   : r3_req_addr;
  assign fill_v     = sel ? r4_fill_v     : r3_fill_v;
  assign fill_vpn   = sel ? r4_fill_vpn   : {9'd0, r3_fill_vpn};
  assign fill_ppn   = sel ? r4_fill_ppn   : r3_fill_ppn;
  assign fill_level = sel ? r4_fill_level : r3_fill_level;
  assign fill_flags = sel ? r4_fill_flags : r3_fill_flags;
  assign fill_fault = sel ? r4_fill_fault : r3_fill_fault;

  typedef struct {
    logic [35:0] vpn;
    logic [43:0] ppn;
    logic [1:0]  lvl;
    logic [7:0]  flags;
    logic        fault;
  } fill_t;

  logic [55:0] exp_addr_q[$];
  logic [63:0] resp_q[$];
  fill_t       exp_fill_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_fill(input logic [35:0] vpn, input logic [43:0] ppn, input logic [1:0] lvl,
                          input logic [7:0] flags, input logic fault);
    fill_t e;
    e.vpn = vpn; e.ppn = ppn; e.lvl = lvl; e.flags = flags; e.fault = fault;
    exp_fill_q.push_back(e);
  endtask

  // Runs one walk to completion. The first request may be held off for
  // req_stall cycles and the fill for fill_stall cycles. exp_lat > 0 checks
  // the cycle (accept edge = cycle 0) on which the fill first appears.
  task automatic do_walk(input logic [43:0] satp_v, input logic [35:0] vpn_v, input int exp_nreq,
                         input int req_stall, input int fill_stall, input int exp_lat);
    int cyc, nreq, rs, fs;
    bit done, resp_pend, seen_req, seen_fill;
    logic [55:0] held_addr;
    logic [43:0] held_ppn;
    logic [7:0]  held_flags;
    fill_t e;
    cyc = 1; nreq = 0; rs = req_stall; fs = fill_stall;
    done = 0; resp_pend = 0; seen_req = 0; seen_fill = 0;
    held_addr = '0; held_ppn = '0; held_flags = '0;
    chk("walk_ready_idle", walk_ready, 1);
    satp = satp_v; walk_vpn = vpn_v; walk_v = 1'b1;
    @(negedge gclk);
    walk_v = 1'b0;
    while (!done && cyc < 400) begin
      mem_req_ready = 1'b0; fill_ready = 1'b0; mem_resp_v = 1'b0;
      if (resp_pend) begin
        resp_pend = 0;
        chk("resp_avail", (resp_q.size() > 0), 1);
        mem_resp_v = 1'b1;
        mem_resp_data = (resp_q.size() > 0) ? resp_q.pop_front() : 64'd0;
      end else if (req_v) begin
        if (!seen_req) begin
          seen_req = 1; held_addr = req_addr;
          chk("req_expected", (exp_addr_q.size() > 0), 1);
          if (exp_addr_q.size() > 0) chk("req_addr", req_addr, exp_addr_q.pop_front());
        end else begin
          chk("req_addr_hold", req_addr, held_addr);
        end
        if (rs > 0 && nreq == 0) rs--;
        else begin
          mem_req_ready = 1'b1; nreq++; seen_req = 0; resp_pend = 1;
        end
      end else if (fill_v) begin
        if (!seen_fill) begin
          seen_fill = 1; held_ppn = fill_ppn; held_flags = fill_flags;
          if (exp_lat > 0) chk("fill_latency", cyc, exp_lat);
        end else begin
          chk("fill_hold_ppn", fill_ppn, held_ppn);
          chk("fill_hold_flags", fill_flags, held_flags);
        end
        if (fs > 0) begin
          fs--;
          chk("walk_ready_busy", walk_ready, 0);
        end else begin
          fill_ready = 1'b1; done = 1;
          chk("fill_expected", (exp_fill_q.size() > 0), 1);
          if (exp_fill_q.size() > 0) begin
            e = exp_fill_q.pop_front();
            chk("fill_vpn", fill_vpn, e.vpn);
            chk("fill_ppn", fill_ppn, e.ppn);
            chk("fill_level", fill_level, e.lvl);
            chk("fill_flags", fill_flags, e.flags);
            chk("fill_fault", fill_fault, e.fault);
          end
        end
      end
      @(negedge gclk);
      cyc++;
    end
    mem_req_ready = 1'b0; fill_ready = 1'b0; mem_resp_v = 1'b0;
    chk("walk_done", done, 1);
    chk("req_count", nreq, exp_nreq);
    chk("addr_q_drained", exp_addr_q.size(), 0);
    chk("walk_ready_after", walk_ready, 1);
    exp_addr_q.delete(); resp_q.delete(); exp_fill_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held
    repeat (3) @(negedge gclk);
    chk("rst_walk_ready", walk_ready, 0);
    chk("rst_req_v", req_v, 0);
    chk("rst_fill_v", fill_v, 0);
    chk("rst_fill_fault", fill_fault, 0);
    chk("rst_fill_ppn", fill_ppn, 0);
    chk("rst_fill_flags", fill_flags, 0);
    chk("rst_fill_level", fill_level, 0);
    chk("rst_fill_vpn", fill_vpn, 0);
    reset_n = 1'b1;
    @(negedge gclk);
    chk("ready_after_rst", r3_walk_ready, 1);
    chk("ready_after_rst4", r4_walk_ready, 1);

    // Full 4 KiB walk, zero-wait memory
    exp_addr_q = '{56'h80000008, 56'h80001010, 56'h80002018};
    resp_q     = '{64'h20000401, 64'h20000801, 64'h048D14CF};
    exp_fill(36'h40403, 44'h12345, 2'd0, 8'hCF, 1'b0);
    do_walk(44'h80000, 36'h40403, 3, 0, 0, 7);

    // Gigapage leaf at the root level
    exp_addr_q = '{56'h80000008};
    resp_q     = '{64'h1000000F};
    exp_fill(36'h40403, 44'h40403, 2'd2, 8'h0F, 1'b0);
    do_walk(44'h80000, 36'h40403, 1, 0, 0, 3);

    // Misaligned gigapage
    exp_addr_q = '{56'h80000008};
    resp_q     = '{64'h1000040F};
    exp_fill(36'h40403, 44'h0, 2'd2, 8'h0F, 1'b1);
    do_walk(44'h80000, 36'h40403, 1, 0, 0, 0);

    // Invalid PTE at level 1
    exp_addr_q = '{56'h80000008, 56'h80001010};
    resp_q     = '{64'h20000401, 64'h20000800};
    exp_fill(36'h40403, 44'h0, 2'd1, 8'h00, 1'b1);
    do_walk(44'h80000, 36'h40403, 2, 0, 0, 0);

    // Pointer at level 0
    exp_addr_q = '{56'h80000008, 56'h80001010, 56'h80002018};
    resp_q     = '{64'h20000401, 64'h20000801, 64'h20000C01};
    exp_fill(36'h40403, 44'h0, 2'd0, 8'h01, 1'b1);
    do_walk(44'h80000, 36'h40403, 3, 0, 0, 0);

    // W without R
    exp_addr_q = '{56'h80000008};
    resp_q     = '{64'h20000405};
    exp_fill(36'h40403, 44'h0, 2'd2, 8'h05, 1'b1);
    do_walk(44'h80000, 36'h40403, 1, 0, 0, 0);

    // Request backpressure: first request stalled 5 cycles
    exp_addr_q = '{56'h12345FF8, 56'h00ABC000, 56'h00DEFD58};
    resp_q     = '{64'h002AF001, 64'h0037BC01, 64'h3FB72EA60C3};
    exp_fill(36'h7FC01AB, 44'hFEDCBA98, 2'd0, 8'hC3, 1'b0);
    do_walk(44'h12345, 36'h7FC01AB, 3, 5, 0, 0);

    // Fill backpressure on a megapage result
    exp_addr_q = '{56'h80000008, 56'h80001010};
    resp_q     = '{64'h20000401, 64'h1568000B};
    exp_fill(36'h40403, 44'h55A03, 2'd1, 8'h0B, 1'b0);
    do_walk(44'h80000, 36'h40403, 2, 0, 3, 0);

    // Reset while waiting for a response; stale response afterwards
    satp = 44'h80000; walk_vpn = 36'h40403; walk_v = 1'b1;
    @(negedge gclk);
    walk_v = 1'b0;
    chk("rstwait_req_v", req_v, 1);
    mem_req_ready = 1'b1;
    @(negedge gclk);
    mem_req_ready = 1'b0;
    chk("rstwait_in_wait", req_v, 0);
    reset_n = 1'b0;
    @(negedge gclk);
    chk("rstwait_ready_low", walk_ready, 0);
    chk("rstwait_fill_v", fill_v, 0);
    reset_n = 1'b1;
    @(negedge gclk);
    mem_resp_v = 1'b1; mem_resp_data = 64'h20000401;
    @(negedge gclk);
    mem_resp_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_fill_v", fill_v, 0);
      chk("stale_req_v", req_v, 0);
      chk("stale_ready", walk_ready, 1);
      @(negedge gclk);
    end
    exp_addr_q = '{56'h80000008, 56'h80001010, 56'h80002018};
    resp_q     = '{64'h20000401, 64'h20000801, 64'h048D14CF};
    exp_fill(36'h40403, 44'h12345, 2'd0, 8'hCF, 1'b0);
    do_walk(44'h80000, 36'h40403, 3, 0, 0, 7);

    // Four-level walk on the deeper instance
    sel = 1'b1;
    exp_addr_q = '{56'h80000008, 56'h80001010, 56'h80002018, 56'h80003020};
    resp_q     = '{64'h20000401, 64'h20000801, 64'h20000C01, 64'h048D14CF};
    exp_fill(36'h8080604, 44'h12345, 2'd0, 8'hCF, 1'b0);
    do_walk(44'h80000, 36'h8080604, 4, 0, 0, 9);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_mmu_ptw.md
# bp_mmu_ptw

Parametrised hardware page-table walker for BlackParrot virtual memory. Sits between a TLB miss port and the memory request path, and fetches page-table entries level by level from the root page number. Returns a translated PPN, superpage level and PTE flags, or a page fault. Depth, widths and PTE size are parameters, so SV39 and deeper schemes (SV48) share one block.

## Interface
- `vaddr_width_p`, 39, virtual address width
- `paddr_width_p`, 56, physical address width
- `page_table_depth_p`, 3, number of page-table levels
- `pte_width_p`, 64, PTE width in bits
- `page_offset_width_p`, 12, log2 of the page size in bytes
- Derived widths:
  - vpn_w = vaddr − offset (27)
  - ppn_w = paddr − offset (44)
  - idx_w = vpn_w / depth (9)
  - lvl_w = clog2(depth)
- Legal parameter sets satisfy idx_w + log2(pte_width_p/8) == page_offset_width_p.
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  reset; one clock, synchronous, active-low
- `satp_ppn_i`  in  ppn_w  root page-table PPN; sampled at walk accept
- `walk_v_i`  in  1  walk request valid
- `walk_vpn_i`  in  vpn_w  VPN to translate
- `walk_ready_o`  out  1  ready to accept a walk
- `mem_req_v_o`  out  1  PTE read request valid
- `mem_req_addr_o`  out  paddr_w  PTE byte address
- `mem_req_ready_i`  in  1  memory accepts the request
- `mem_resp_v_i`  in  1  PTE data valid
- `mem_resp_data_i`  in  pte_width_p  PTE
- `fill_v_o`  out  1  result valid
- `fill_ready_i`  in  1  consumer accepts the result
- `fill_vpn_o`  out  vpn_w  VPN of the walk
- `fill_ppn_o`  out  ppn_w  translated PPN, with superpage bits filled from the VPN
- `fill_level_o`  out  lvl_w  level of the leaf (0 = 4 KiB page)
- `fill_flags_o`  out  8  PTE bits [7:0] (D A G U X W R V)
- `fill_fault_o`  out  1  page fault

## Operation
- States: IDLE, SEND, WAIT, DONE. `walk_ready_o` = (state == IDLE).
- Accept (`walk_v_i & walk_ready_o`):
  - latch the VPN
  - base = `satp_ppn_i`
  - level = depth−1
  - go to SEND
- SEND:
  - `mem_req_v_o` = 1
  - `mem_req_addr_o` = {base, vpn[level*idx_w +: idx_w], log2(pte bytes) zero bits}
  - Address is held stable until `mem_req_ready_i`; on handshake go to WAIT.
- WAIT: on `mem_resp_v_i`, decode the PTE:
  - V = 0, or (R = 0 & W = 1): fault, go to DONE.
  - R or X set (leaf):
    - if level > 0 and the PTE PPN's low level*idx_w bits are nonzero: fault (misaligned superpage)
    - otherwise fill_ppn = PTE PPN with the low level*idx_w bits replaced by the VPN's low level*idx_w bits
    - go to DONE
  - Otherwise (pointer):
    - if level == 0: fault
    - else base = PTE PPN [10 +: ppn_w], level−1, go to SEND
- DONE:
  - `fill_v_o` = 1; all fill outputs stable until `fill_ready_i`, then IDLE.
  - On a fault: `fill_ppn_o` = 0, `fill_flags_o` = the faulting PTE's flags, `fill_level_o` = the level where the fault occurred.
- The A and D bits are passed through, not checked or updated.
- `mem_resp_v_i` outside WAIT is ignored. The response port has no ready; the walker always sinks a response in WAIT.
- Only one walk is in flight; `walk_v_i` is ignored in any non-IDLE state.

## Timing
- Reset (`reset_n_i` = 0 at a clock edge):
  - state = IDLE; `mem_req_v_o`, `fill_v_o`, `fill_fault_o` = 0
  - all fill data = 0
  - `walk_ready_o` = 0 while reset is asserted, 1 from the first cycle after release
- Reset mid-walk aborts the walk with no fill. A stale response that arrives afterwards is ignored.
- All outputs are driven from registers or state, with no input-to-output combinational path. Exception: none; `walk_ready_o` is state-decoded.
- Per level: 1 cycle in SEND (if ready) plus ≥1 cycle in WAIT. The response may arrive at the earliest the cycle after the request handshake.
- Example: a 3-level walk with zero-wait memory is accepted at cycle 0 and reaches DONE at cycle 7. With `fill_ready_i` high, `walk_ready_o` is high again at cycle 8.
- Level arithmetic uses lvl_w bits; the decrement never wraps because level 0 pointers fault.

## Test plan
- Full 4 KiB walk: satp_ppn = 0x80000, vpn = 0x40403.
  - Required addresses: 0x80000008, 0x80001010, 0x80002018.
  - Responses: 0x20000401, 0x20000801, 0x48D14CF.
  - Required fill: ppn = 0x12345, level = 0, flags = 0xCF, fault = 0.
- Gigapage: level-2 response PTE = (0x40000<<10)|0x0F.
  - Required fill: ppn = 0x40403, level = 2, fault = 0, after exactly 1 memory request.
- Faults, each with fault = 1:
  - misaligned gigapage ppn 0x40001: level = 2
  - V = 0 at level 1: after 2 requests
  - pointer at level 0: level = 0
  - W = 1 with R = 0
- Backpressure:
  - `mem_req_ready_i` low for 5 cycles: address held constant, one request issued.
  - `fill_ready_i` low for 3 cycles: `fill_v_o` and data held, `walk_ready_o` = 0 throughout.
- Reset during WAIT: the response arrives after release → no fill and no request. A new walk then completes normally.
- Reconfigure for depth = 4, vaddr = 48: a 4-level walk issues 4 requests with the correct idx fields.
